regfile_dump_engine: RTL and testbench

- Debug/trace reader that sits on the read side of the 32 x 32 register file, driving one read-select port and sampling its combinational read data.
- On a start pulse it walks a range of register indices and streams each word out over a valid/ready handshake, tagged with index and last flag.
- Accumulates an XOR checksum of the streamed words and pulses done on completion.
- Used by the debug/halt path to dump architectural state without touching the write port.

---
 rtl/regfile_dump_engine.sv | 154 +++++++++++++++
 tb/tb_regfile_dump_engine.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_engine.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_engine
// Purpose  : Debug/trace reader for the register file. On an accepted start
//            it walks register indices first_reg..last_reg (wrapping past the
//            top index), reads each word through the read-select port and
//            streams it out over a valid/ready handshake. The handshake
//            carries the index and a last flag. It also keeps an XOR checksum
//            of the accepted words and pulses done when the walk finishes.
// Ports    : CLK, nRST             clock, async active-low reset
//            start, abort          dump request / cancel
//            first_reg, last_reg   index range, latched on accepted start
//            rsel, rdat            register file read select / read data
//            dump_valid/ready      output stream handshake
//            dump_data/index/last  output stream payload
//            busy, done, checksum  status
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rsel,
  input  logic [DATA_W-1:0] rdat,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_index,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic                dlast_q, dlast_d;
  logic [DATA_W-1:0]   ck_q, ck_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      index_q <= '0;
      dlast_q <= 1'b0;
      ck_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      index_q <= index_d;
      dlast_q <= dlast_d;
      ck_q    <= ck_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    dlast_d = dlast_q;
    ck_d    = ck_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = first_reg;
          last_d  = last_reg;
          ck_d    = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        if (abort) begin
          valid_d = 1'b0;
          dlast_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          // rdat is combinational from rsel (= idx_q), so it is valid now
          data_d  = rdat;
          index_d = idx_q;
          dlast_d = (idx_q == last_q);
          valid_d = 1'b1;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        // abort wins over a coincident handshake; that word is not counted
        if (abort) begin
          valid_d = 1'b0;
          dlast_d = 1'b0;
          state_d = S_IDLE;
        end else if (dump_ready) begin
          ck_d    = ck_q ^ data_q;
          valid_d = 1'b0;
          if (dlast_q) begin
            state_d = S_DONE;
          end else begin
            // natural ADDR_W-bit overflow gives the wrap past the top index
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // idx_q only changes on entry to READ, so rsel holds its value elsewhere
  assign rsel       = idx_q;
  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_index = index_q;
  assign dump_last  = dlast_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign checksum   = ck_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_engine
// Purpose  : Self-checking bench for regfile_dump_engine. A register file
//            model drives rdat. Stimulus pushes the expected word stream into
//            a queue, and a negedge monitor pops and compares each accepted
//            word. Dumps with random ranges, contents and backpressure are
//            mixed with directed reset, wrap, backpressure and abort cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_engine;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          start, abort, dump_ready;
  logic [AW-1:0] first_reg, last_reg;
  logic [AW-1:0] rsel;
  logic [DW-1:0] rdat;
  logic          dump_valid, dump_last, busy, done;
  logic [DW-1:0] dump_data, checksum;
  logic [AW-1:0] dump_index;

  logic [DW-1:0] regs [32];

  always #5 CLK = ~CLK;

  assign rdat = regs[rsel];

  regfile_dump_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .abort      (abort),
    .first_reg  (first_reg),
    .last_reg   (last_reg),
    .rsel       (rsel),
    .rdat       (rdat),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_index (dump_index),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          expq [$];
  int            tests    = 0;
  int            fails    = 0;
  int            done_cnt = 0;
  int            hs_cnt   = 0;
  logic [DW-1:0] ck_total = '0;   // XOR of every word ever accepted
  logic [DW-1:0] ck_base;         // ck_total at the latest start
  int            hs_base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t          e_mon;
  logic          hold_p = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;
  logic          hold_l;

  always @(negedge CLK) begin
    if (!nRST) begin
      hold_p = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (hold_p && dump_valid) begin
        chk("hold_data",  dump_data, hold_d);
        chk("hold_index", 32'(dump_index), 32'(hold_i));
        chk("hold_last",  32'(dump_last), 32'(hold_l));
      end
      if (dump_valid && dump_ready && !abort) begin
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got index %0d data %h, expected no word", dump_index, dump_data);
        end else begin
          e_mon = expq.pop_front();
          chk("word_index", 32'(dump_index), 32'(e_mon.idx));
          chk("word_data",  dump_data, e_mon.data);
          chk("word_last",  32'(dump_last), 32'(e_mon.last));
          ck_total = ck_total ^ e_mon.data;
          hs_cnt++;
        end
      end
      hold_p = dump_valid && !dump_ready;
      hold_d = dump_data;
      hold_i = dump_index;
      hold_l = dump_last;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int n;
    exp_t e;
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    for (int k = 0; k < n; k++) begin
      e.idx  = AW'((int'(f) + k) % 32);
      e.data = regs[e.idx];
      e.last = (k == n - 1);
      expq.push_back(e);
    end
    ck_base   = ck_total;
    hs_base   = hs_cnt;
    first_reg = f;
    last_reg  = l;
    start     = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_ready, input bit spur, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge CLK);
      #1 start = 1'b0;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      if (rnd_ready) dump_ready = 1'($urandom_range(0, 1));
      if (spur && $urandom_range(0, 2) == 0) begin
        start     = 1'b1;
        first_reg = AW'($urandom);
        last_reg  = AW'($urandom);
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: busy still %0d, expected 0 within 2000 cycles", name, busy);
    end
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (dump_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_valid_timeout: dump_valid %0d, expected 1", name, dump_valid);
    end
  endtask

  task automatic finish_check(input string name, input int done_before);
    chk({name, "_queue_empty"}, 32'(expq.size()), 32'd0);
    chk({name, "_checksum"}, checksum, ck_total ^ ck_base);
    chk({name, "_done_pulses"}, 32'(done_cnt - done_before), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    expq.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rsel"},     32'(rsel), 32'd0);
    chk({name, "_valid"},    32'(dump_valid), 32'd0);
    chk({name, "_data"},     dump_data, 32'd0);
    chk({name, "_index"},    32'(dump_index), 32'd0);
    chk({name, "_last"},     32'(dump_last), 32'd0);
    chk({name, "_busy"},     32'(busy), 32'd0);
    chk({name, "_done"},     32'(done), 32'd0);
    chk({name, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    nRST       = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    dump_ready = 1'b0;
    first_reg  = '0;
    last_reg   = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    repeat (2) @(posedge CLK);
    #1 check_reset_outputs("reset");
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // in-order dump 1..4 with latency check and spurious starts
    regs[1] = 32'h11111111;
    regs[2] = 32'h22222222;
    regs[3] = 32'h44444444;
    regs[4] = 32'h88888888;
    dump_ready = 1'b1;
    d0 = done_cnt;
    start_dump(5'd1, 5'd4);
    chk("lat_valid_n1", 32'(dump_valid), 32'd0);
    chk("lat_busy_n1",  32'(busy), 32'd1);
    @(posedge CLK);
    #1;
    chk("lat_valid_n2", 32'(dump_valid), 32'd1);
    chk("lat_index_n2", 32'(dump_index), 32'd1);
    wait_idle(1'b0, 1'b1, "seq");
    finish_check("seq", d0);
    chk("seq_checksum_const", checksum, 32'hFFFFFFFF);

    // wrap 30 -> 1
    regs[30] = 32'hA;
    regs[31] = 32'hB;
    regs[1]  = 32'hC;
    d0 = done_cnt;
    start_dump(5'd30, 5'd1);
    wait_idle(1'b0, 1'b1, "wrap");
    finish_check("wrap", d0);

    // single word with 7 cycles of backpressure
    regs[5]    = 32'hDEADBEEF;
    dump_ready = 1'b0;
    d0 = done_cnt;
    start_dump(5'd5, 5'd5);
    wait_valid("bp");
    for (int c = 0; c < 7; c++) begin
      chk("bp_data",  dump_data, 32'hDEADBEEF);
      chk("bp_index", 32'(dump_index), 32'd5);
      @(posedge CLK);
      #1;
    end
    chk("bp_last", 32'(dump_last), 32'd1);
    dump_ready = 1'b1;
    wait_idle(1'b0, 1'b0, "bp");
    finish_check("bp", d0);
    chk("bp_checksum_const", checksum, 32'hDEADBEEF);

    // abort together with the handshake of the third word
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    dump_ready = 1'b1;
    d0 = done_cnt;
    start_dump(5'd0, 5'd31);
    for (int c = 0; c < 50; c++) begin
      if (dump_valid && (hs_cnt - hs_base) == 2) break;
      @(posedge CLK);
      #1;
    end
    chk("abort_precond_valid", 32'(dump_valid), 32'd1);
    abort = 1'b1;
    @(posedge CLK);
    #1 abort = 1'b0;
    chk("abort_busy",     32'(busy), 32'd0);
    chk("abort_valid",    32'(dump_valid), 32'd0);
    chk("abort_last",     32'(dump_last), 32'd0);
    chk("abort_words",    32'(hs_cnt - hs_base), 32'd2);
    chk("abort_checksum", checksum, regs[0] ^ regs[1]);
    @(negedge CLK);
    chk("abort_no_done",  32'(done_cnt - d0), 32'd0);
    expq.delete();
    @(posedge CLK);
    #1;

    // asynchronous reset while a word is waiting in SEND
    dump_ready = 1'b0;
    start_dump(5'd3, 5'd9);
    wait_valid("rst");
    #1 nRST = 1'b0;
    #1 check_reset_outputs("async_reset");
    #1 nRST = 1'b1;
    expq.delete();
    @(posedge CLK);
    #1 chk("post_reset_busy", 32'(busy), 32'd0);

    // randomized dumps with random backpressure and spurious starts
    for (int t = 0; t < 15; t++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      dump_ready = 1'($urandom_range(0, 1));
      d0 = done_cnt;
      start_dump(AW'($urandom), AW'($urandom));
      wait_idle(1'b1, 1'b1, "rand");
      finish_check("rand", d0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
